// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT pipeline types, constants and bit-reversal helper
package fft_pkg;

  localparam int DEFAULT_FLOAT_PRECISION = 64;
  localparam int MAX_LOG2N = 12;

  typedef struct packed {
    logic [DEFAULT_FLOAT_PRECISION-1:0] re;
    logic [DEFAULT_FLOAT_PRECISION-1:0] im;
  } complex_t;

  // Reverse the low `width` bits of value; bits above width come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                  input int width);
    logic [MAX_LOG2N-1:0] rev;
    rev = {<<{value}};
    return rev >> (MAX_LOG2N - width);
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// rtl/fft_bitrev_reorder_if.sv - sample stream in/out bundle of the reorder stage
// o_last exists only when FFT_REORDER_LAST_EN is defined.
interface fft_bitrev_reorder_if
  import fft_pkg::*;
#(
  parameter int FLOAT_PRECISION = DEFAULT_FLOAT_PRECISION
);

  logic                       i_valid;
  logic [FLOAT_PRECISION-1:0] di_re;
  logic [FLOAT_PRECISION-1:0] di_im;
  logic                       o_valid;
  logic [FLOAT_PRECISION-1:0] do_re;
  logic [FLOAT_PRECISION-1:0] do_im;
  logic                       o_busy;
`ifdef FFT_REORDER_LAST_EN
  logic                       o_last;
`endif

  modport slave (
    input  i_valid,
    input  di_re,
    input  di_im,
    output o_valid,
    output do_re,
    output do_im,
`ifdef FFT_REORDER_LAST_EN
    output o_last,
`endif
    output o_busy
  );

  modport master (
    output i_valid,
    output di_re,
    output di_im,
    input  o_valid,
    input  do_re,
    input  do_im,
`ifdef FFT_REORDER_LAST_EN
    input  o_last,
`endif
    input  o_busy
  );

endinterface

// File: rtl/fft_reorder_bank_ram.sv
// rtl/fft_reorder_bank_ram.sv - two-bank simple dual-port sample memory
// Registered read port; the read register clears on rst so outputs start at zero.
module fft_reorder_bank_ram
  import fft_pkg::*;
#(
  parameter int DATA_W = 2 * DEFAULT_FLOAT_PRECISION,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural order
// Optional frame-end marker o_last is built when FFT_REORDER_LAST_EN is defined.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int FLOAT_PRECISION = DEFAULT_FLOAT_PRECISION,
  parameter int LOG2N           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  fft_bitrev_reorder_if.slave  bus
);

  typedef struct packed {
    logic [FLOAT_PRECISION-1:0] re;
    logic [FLOAT_PRECISION-1:0] im;
  } sample_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  rd_state_t        state, state_next;
  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_next;
  logic             rd_bank, rd_bank_next;
  logic             valid_q, valid_next;
`ifdef FFT_REORDER_LAST_EN
  logic             last_q, last_next;
`endif

  logic             wr_en;
  logic             rd_start;
  logic             rd_last;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr;
  sample_t          wr_sample;
  sample_t          rd_sample;

  assign wr_en    = ena & bus.i_valid;
  assign rd_start = wr_en & (wr_cnt == '1);
  assign rd_last  = (rd_cnt == '1);
  assign rd_en    = ena & (state == RD_DRAIN);
  assign rd_addr  = LOG2N'(bitrev(MAX_LOG2N'(rd_cnt), LOG2N));

  assign wr_sample.re = bus.di_re;
  assign wr_sample.im = bus.di_im;

  // wr_cnt wraps naturally at N-1; the bank flips on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == '1) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      valid_q <= 1'b0;
`ifdef FFT_REORDER_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      rd_cnt  <= rd_cnt_next;
      rd_bank <= rd_bank_next;
      valid_q <= valid_next;
`ifdef FFT_REORDER_LAST_EN
      last_q  <= last_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    rd_cnt_next  = rd_cnt;
    rd_bank_next = rd_bank;
    valid_next   = valid_q;
`ifdef FFT_REORDER_LAST_EN
    last_next    = last_q;
`endif
    if (ena) begin
      unique case (state)
        RD_IDLE: begin
          valid_next = 1'b0;
`ifdef FFT_REORDER_LAST_EN
          last_next  = 1'b0;
`endif
          if (rd_start) begin
            state_next   = RD_DRAIN;
            rd_bank_next = wr_bank;
            rd_cnt_next  = '0;
          end
        end
        RD_DRAIN: begin
          valid_next  = 1'b1;
          rd_cnt_next = rd_cnt + 1'b1;
`ifdef FFT_REORDER_LAST_EN
          last_next   = rd_last;
`endif
          // A frame completing on the final drain edge chains straight into the other bank.
          if (rd_last) begin
            if (rd_start) begin
              rd_bank_next = wr_bank;
            end else begin
              state_next = RD_IDLE;
            end
          end
        end
        default: state_next = RD_IDLE;
      endcase
    end
  end

  fft_reorder_bank_ram #(
    .DATA_W (2 * FLOAT_PRECISION),
    .ADDR_W (LOG2N)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (wr_sample),
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_sample)
  );

  assign bus.o_valid = valid_q;
  assign bus.do_re   = rd_sample.re;
  assign bus.do_im   = rd_sample.im;
  assign bus.o_busy  = (wr_cnt != '0) | (state == RD_DRAIN);
`ifdef FFT_REORDER_LAST_EN
  assign bus.o_last  = last_q;
`endif

endmodule
